// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hard-wired control sequencer:
// opcodes, IR field positions and the sequencer state encoding.
package control_sequencer_pkg;

   localparam int IR_OP_HI = 31;
   localparam int IR_OP_LO = 27;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_ROR  = 5'b01001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      S_RST,
      S_T0,
      S_T1,
      S_T1W,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_HALT,
      S_FAULT
   } state_t;

   function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
      return ir[IR_OP_HI:IR_OP_LO];
   endfunction

endpackage

// File: rtl/control_sequencer_op_decoder.sv
// Opcode classifier: exactly one of the four class flags is set
// for any opcode value.
module control_sequencer_op_decoder
   import control_sequencer_pkg::*;
(
   input  logic [4:0] opcode,
   output logic       is_alu,
   output logic       is_nop,
   output logic       is_halt,
   output logic       is_illegal
);

   always_comb begin
      is_alu     = 1'b0;
      is_nop     = 1'b0;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      unique case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_ROL, OP_ROR: is_alu = 1'b1;
         OP_NOP:  is_nop  = 1'b1;
         OP_HALT: is_halt = 1'b1;
         default: is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired fetch/decode/execute sequencer driving the datapath strobes;
// outputs decode from the state register and the IR opcode.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
)
(
   input  logic        Clock,
   input  logic        Clear,
   input  logic        Run,
   input  logic        Mem_rdy,
   input  logic [31:0] IR,
   output logic        PCout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        MARin,
   output logic        PCin,
   output logic        MDRin,
   output logic        Read,
   output logic        IRin,
   output logic        Yin,
   output logic        IncPC,
   output logic        ZLowIn,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic [4:0]  op_code,
   output logic        Halted,
   output logic        Illegal,
   output logic        Bus_err
);

   localparam logic [3:0] TIMEOUT = 4'(MEM_TIMEOUT);

   state_t     state;
   state_t     state_nx;
   logic [3:0] wait_cnt;
   logic [3:0] wait_cnt_nx;
   logic [4:0] opcode;
   logic       is_alu;
   logic       is_nop;
   logic       is_halt;
   logic       is_illegal;
   logic       unused_ir;

   assign opcode    = ir_opcode(IR);
   assign unused_ir = ^IR[26:0];

   control_sequencer_op_decoder u_dec (
      .opcode     (opcode),
      .is_alu     (is_alu),
      .is_nop     (is_nop),
      .is_halt    (is_halt),
      .is_illegal (is_illegal)
   );

   always_ff @(posedge Clock) begin
      if (!Clear) begin
         state    <= S_RST;
         wait_cnt <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      PCout   = 1'b0;
      Zlowout = 1'b0;
      MDRout  = 1'b0;
      MARin   = 1'b0;
      PCin    = 1'b0;
      MDRin   = 1'b0;
      Read    = 1'b0;
      IRin    = 1'b0;
      Yin     = 1'b0;
      IncPC   = 1'b0;
      ZLowIn  = 1'b0;
      Gra     = 1'b0;
      Grb     = 1'b0;
      Grc     = 1'b0;
      Rin     = 1'b0;
      Rout    = 1'b0;
      op_code = 5'd0;
      Halted  = 1'b0;
      Illegal = 1'b0;
      Bus_err = 1'b0;
      unique case (state)
         S_RST: state_nx = S_T0;
         S_T0: begin
            // a stalled T0 drives nothing onto the bus
            if (Run) begin
               PCout    = 1'b1;
               MARin    = 1'b1;
               IncPC    = 1'b1;
               ZLowIn   = 1'b1;
               state_nx = S_T1;
            end
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            if (Mem_rdy) begin
               state_nx = S_T2;
            end else begin
               state_nx    = S_T1W;
               wait_cnt_nx = '0;
            end
         end
         S_T1W: begin
            Read  = 1'b1;
            MDRin = 1'b1;
            if (Mem_rdy)
               state_nx = S_T2;
            else if (wait_cnt + 4'd1 == TIMEOUT)
               state_nx = S_FAULT;
            else
               wait_cnt_nx = wait_cnt + 4'd1;
         end
         S_T2: begin
            MDRout   = 1'b1;
            IRin     = 1'b1;
            state_nx = S_T3;
         end
         S_T3: begin
            unique case (1'b1)
               is_alu: begin
                  Grb      = 1'b1;
                  Rout     = 1'b1;
                  Yin      = 1'b1;
                  state_nx = S_T4;
               end
               is_nop:  state_nx = S_T0;
               is_halt: state_nx = S_HALT;
               is_illegal: begin
                  Illegal  = 1'b1;
                  state_nx = S_T0;
               end
            endcase
         end
         S_T4: begin
            Grc      = 1'b1;
            Rout     = 1'b1;
            ZLowIn   = 1'b1;
            op_code  = opcode;
            state_nx = S_T5;
         end
         S_T5: begin
            Zlowout  = 1'b1;
            Gra      = 1'b1;
            Rin      = 1'b1;
            state_nx = S_T0;
         end
         S_HALT:  Halted  = 1'b1;
         S_FAULT: Bus_err = 1'b1;
         default: state_nx = S_RST;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized directed bench: expected strobe traces are built per
// instruction from its class, wait states and timeout.
module tb_control_sequencer;

   localparam int TMO = 15;

   localparam logic [23:0] PCO   = 24'd1 << 23;
   localparam logic [23:0] ZLO   = 24'd1 << 22;
   localparam logic [23:0] MDRO  = 24'd1 << 21;
   localparam logic [23:0] MARI  = 24'd1 << 20;
   localparam logic [23:0] PCI   = 24'd1 << 19;
   localparam logic [23:0] MDRI  = 24'd1 << 18;
   localparam logic [23:0] RD    = 24'd1 << 17;
   localparam logic [23:0] IRI   = 24'd1 << 16;
   localparam logic [23:0] YI    = 24'd1 << 15;
   localparam logic [23:0] INCPC = 24'd1 << 14;
   localparam logic [23:0] ZLI   = 24'd1 << 13;
   localparam logic [23:0] GRA   = 24'd1 << 12;
   localparam logic [23:0] GRB   = 24'd1 << 11;
   localparam logic [23:0] GRC   = 24'd1 << 10;
   localparam logic [23:0] RI    = 24'd1 << 9;
   localparam logic [23:0] RO    = 24'd1 << 8;
   localparam logic [23:0] HLT   = 24'd1 << 7;
   localparam logic [23:0] ILL   = 24'd1 << 6;
   localparam logic [23:0] BERR  = 24'd1 << 5;

   localparam logic [23:0] E_T0  = PCO | MARI | INCPC | ZLI;
   localparam logic [23:0] E_T1  = ZLO | PCI | RD | MDRI;
   localparam logic [23:0] E_T1W = RD | MDRI;
   localparam logic [23:0] E_T2  = MDRO | IRI;
   localparam logic [23:0] E_T3A = GRB | RO | YI;
   localparam logic [23:0] E_T4  = GRC | RO | ZLI;
   localparam logic [23:0] E_T5  = ZLO | GRA | RI;

   localparam logic [31:0] I_ROR  = 32'h4B320000;
   localparam logic [31:0] I_HALT = 32'hD8000000;
   localparam logic [31:0] I_BAD  = 32'hF8000000;

   logic        Clock;
   logic        Clear;
   logic        Run;
   logic        Mem_rdy;
   logic [31:0] IR;
   logic        PCout, Zlowout, MDRout, MARin, PCin, MDRin;
   logic        Read, IRin, Yin, IncPC, ZLowIn;
   logic        Gra, Grb, Grc, Rin, Rout;
   logic [4:0]  op_code;
   logic        Halted, Illegal, Bus_err;
   logic [23:0] obs;

   int compared;
   int mismatched;

   control_sequencer #(.MEM_TIMEOUT(TMO)) dut (
      .Clock   (Clock),
      .Clear   (Clear),
      .Run     (Run),
      .Mem_rdy (Mem_rdy),
      .IR      (IR),
      .PCout   (PCout),
      .Zlowout (Zlowout),
      .MDRout  (MDRout),
      .MARin   (MARin),
      .PCin    (PCin),
      .MDRin   (MDRin),
      .Read    (Read),
      .IRin    (IRin),
      .Yin     (Yin),
      .IncPC   (IncPC),
      .ZLowIn  (ZLowIn),
      .Gra     (Gra),
      .Grb     (Grb),
      .Grc     (Grc),
      .Rin     (Rin),
      .Rout    (Rout),
      .op_code (op_code),
      .Halted  (Halted),
      .Illegal (Illegal),
      .Bus_err (Bus_err)
   );

   assign obs = {PCout, Zlowout, MDRout, MARin, PCin, MDRin,
                 Read, IRin, Yin, IncPC, ZLowIn,
                 Gra, Grb, Grc, Rin, Rout,
                 Halted, Illegal, Bus_err, op_code};

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // one clock: drive inputs after negedge, check before posedge
   task automatic cyc(input logic c, input logic r, input logic m,
                      input logic [31:0] i, input logic [23:0] e,
                      input string tag, input bit chk);
      int n1;
      @(negedge Clock);
      Clear   = c;
      Run     = r;
      Mem_rdy = m;
      IR      = i;
      #1;
      if (chk) begin
         compared++;
         assert (obs === e) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
      n1 = $countones({PCout, Zlowout, MDRout, Rout});
      compared++;
      assert (n1 <= 1) else begin
         mismatched++;
         $error("FAIL bus_mutex %s: observed %0d drivers expected <=1",
                tag, n1);
      end
   endtask

   task automatic stall();
      cyc(1'b1, 1'b0, rb(), $urandom, 24'd0, "t0_stall", 1'b1);
   endtask

   task automatic fetch(input int waits, input bit to);
      int n;
      n = to ? TMO : waits;
      cyc(1'b1, 1'b1, rb(), $urandom, E_T0, "t0", 1'b1);
      cyc(1'b1, rb(), 1'(waits == 0 && !to), $urandom, E_T1, "t1", 1'b1);
      for (int k = 0; k < n; k++)
         cyc(1'b1, rb(), 1'(!to && k == n - 1), $urandom,
             E_T1W, "t1w", 1'b1);
      if (!to)
         cyc(1'b1, rb(), rb(), $urandom, E_T2, "t2", 1'b1);
   endtask

   task automatic exec(input logic [31:0] ir, input bit abort_t4);
      logic [4:0] op;
      op = ir[31:27];
      if (op >= 5'd3 && op <= 5'd9) begin
         cyc(1'b1, rb(), rb(), ir, E_T3A, "t3_alu", 1'b1);
         if (abort_t4) begin
            cyc(1'b0, rb(), rb(), ir, E_T4 | 24'(op), "t4_abort", 1'b1);
            cyc(1'b1, rb(), rb(), ir, 24'd0, "rst_after_abort", 1'b1);
         end else begin
            cyc(1'b1, rb(), rb(), ir, E_T4 | 24'(op), "t4", 1'b1);
            cyc(1'b1, rb(), rb(), ir, E_T5, "t5", 1'b1);
         end
      end else if (op == 5'd26) begin
         cyc(1'b1, rb(), rb(), ir, 24'd0, "t3_nop", 1'b1);
      end else if (op == 5'd27) begin
         cyc(1'b1, rb(), rb(), ir, 24'd0, "t3_halt", 1'b1);
         repeat (4) cyc(1'b1, rb(), rb(), ir, HLT, "halted", 1'b1);
         cyc(1'b0, rb(), rb(), ir, HLT, "halt_clear", 1'b1);
         cyc(1'b1, rb(), rb(), ir, 24'd0, "rst_after_halt", 1'b1);
      end else begin
         cyc(1'b1, rb(), rb(), ir, ILL, "t3_illegal", 1'b1);
      end
   endtask

   initial begin
      logic [4:0]  op;
      logic [31:0] ir;
      int          pick;
      compared   = 0;
      mismatched = 0;
      Clear   = 1'b0;
      Run     = 1'b0;
      Mem_rdy = 1'b0;
      IR      = '0;

      cyc(1'b0, 1'b1, 1'b1, I_ROR, 24'd0, "init", 1'b0);
      cyc(1'b0, 1'b1, 1'b1, I_ROR, 24'd0, "rst_hold", 1'b1);
      cyc(1'b1, 1'b1, 1'b1, I_ROR, 24'd0, "rst_exit", 1'b1);

      fetch(0, 1'b0);
      exec(I_ROR, 1'b0);
      fetch(3, 1'b0);
      exec(I_ROR, 1'b0);
      fetch(1, 1'b0);
      exec(I_BAD, 1'b0);
      repeat (3) stall();
      fetch(0, 1'b0);
      exec(I_ROR, 1'b1);

      fetch(0, 1'b1);
      repeat (3) cyc(1'b1, rb(), rb(), $urandom, BERR, "fault", 1'b1);
      cyc(1'b0, rb(), rb(), $urandom, BERR, "fault_clear", 1'b1);
      cyc(1'b1, rb(), rb(), $urandom, 24'd0, "rst_after_fault", 1'b1);

      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 2)) stall();
         pick = $urandom_range(0, 9);
         if (pick < 6) begin
            op = 5'(3 + $urandom_range(0, 6));
         end else if (pick < 8) begin
            op = 5'd26;
         end else if (pick == 8) begin
            do op = 5'($urandom);
            while ((op >= 5'd3 && op <= 5'd9) || op == 5'd26 || op == 5'd27);
         end else begin
            op = 5'd27;
         end
         ir = {op, 27'($urandom)};
         fetch($urandom_range(0, 4), 1'b0);
         exec(ir, $urandom_range(0, 15) == 0);
      end

      fetch(0, 1'b0);
      exec(I_HALT, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
